pipe_sel_mux: RTL and testbench
===============================

Name: pipe_sel_mux

Overview:
- Parametrised, registered N-input operand-select mux for the pipelined MIPS datapath (ALU-source / forwarding select between EX, MEM, WB values).
- One-cycle latency, with valid tracking, stall hold, flush and out-of-range select detection.
- Out-of-range selects resolve to a defined input, not an inferred latch.
- Replaces the unregistered three-input select in the EX operand path.

Parameters:
- WIDTH, 32, data width of each input and the output.
- NUM_IN, 3, number of inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_IN, 0, input index driven when sel >= NUM_IN; must be < NUM_IN.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  input select.
- in_valid  input  1  the current sel/in_bus pair is a real instruction.
- stall  input  1  hold all output registers.
- flush  input  1  kill the stage (bubble).
- err_clr  input  1  clear sel_err and err_count.
- out_data  output  WIDTH  registered selected operand.
- out_valid  output  1  out_data holds a valid operand.
- out_sel  output  SEL_W  registered effective index used; equals DEFAULT_IN when the select was illegal.
- sel_err  output  1  sticky flag: a valid transaction used an illegal select.
- err_count  output  8  count of illegal-select transactions; saturates at 255.

Behaviour:
- Reset (async assert, release on the next clk edge): out_data=0, out_valid=0, out_sel=0, sel_err=0, err_count=0.
- Effective index: eff = sel if sel < NUM_IN, else DEFAULT_IN. Computed combinationally; no latch on any path; all select values are covered.
- Each rising edge, applied in priority order:
  1. flush=1: out_valid<=0, out_data<=0, out_sel<=0. Flush beats stall.
  2. stall=1 (no flush): out_data, out_valid and out_sel hold their values.
  3. Otherwise: out_data<=in_bus[eff*WIDTH +: WIDTH], out_sel<=eff, out_valid<=in_valid.
- Latency: exactly 1 cycle from sel/in_bus/in_valid to out_*.
- out_data is loaded even when in_valid=0. Consumers qualify it with out_valid.
- Illegal-select event: in_valid=1, sel >= NUM_IN, stall=0, flush=0 on a clock edge.
  - Sets sel_err=1.
  - Increments err_count, saturating at 255 (no wrap to 0).
- Events not counted: illegal selects during stall, during flush, or with in_valid=0.
- err_clr=1 alone: sel_err<=0, err_count<=0.
- err_clr together with an illegal-select event in the same cycle: the event wins. sel_err<=1, err_count<=1.
- NUM_IN = 2**SEL_W: illegal selects cannot occur. sel_err stays 0.
- Reset mid-stall or mid-flush: the reset values apply immediately; stall/flush have no effect until after reset release.

Test Plan:
- Reset, then WIDTH=32, NUM_IN=3, in0=0x11111111, in1=0x22222222, in2=0x33333333; sel=1, in_valid=1 -> next edge out_data=0x22222222, out_valid=1, out_sel=1; sel=2 -> 0x33333333.
- Load sel=0 (out_data=0x11111111), then stall=1 for 3 cycles while sel=2 and inputs change -> out_data stays 0x11111111, out_valid stays 1; on stall release it updates to the new in2 one cycle later.
- stall=1 and flush=1 together with out_valid=1 -> next edge out_valid=0, out_data=0, out_sel=0.
- sel=3, in_valid=1, DEFAULT_IN=0 -> out_data=in0, out_sel=0, sel_err=1, err_count=1; same with in_valid=0 -> counters unchanged; same with stall=1 -> unchanged.
- 300 consecutive illegal valid selects -> err_count saturates at 255; err_clr=1 plus illegal select in the same cycle -> err_count=1, sel_err=1; err_clr alone -> both 0.
- Assert rst asynchronously between edges while out_valid=1, err_count=5 -> all outputs 0 without waiting for clk; first edge after release with sel=2, in_valid=1 -> out_data=in2.

Source files
------------

// File: rtl/pipe_sel_mux.sv
// Registered N-input operand-select mux for the EX operand path.
// One-cycle latency with valid, stall hold, flush and illegal-select tracking.
module pipe_sel_mux #(
   parameter int WIDTH      = 32,
   parameter int NUM_IN     = 3,
   parameter int SEL_W      = 2,
   parameter int DEFAULT_IN = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   input  logic                    stall,
   input  logic                    flush,
   input  logic                    err_clr,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    sel_err,
   output logic [7:0]              err_count
);

   logic             sel_ok;
   logic [SEL_W-1:0] eff;
   logic [WIDTH-1:0] pick;
   logic             bad_ev;

   logic [WIDTH-1:0] data_d, data_q;
   logic             valid_d, valid_q;
   logic [SEL_W-1:0] osel_d, osel_q;
   logic             err_d, err_q;
   logic [7:0]       cnt_d, cnt_q;

   // Resolve the effective index and select the operand; every sel is covered.
   always_comb begin
      sel_ok = (int'(sel) < NUM_IN);
      eff    = sel_ok ? sel : SEL_W'(DEFAULT_IN);
      pick   = in_bus[DEFAULT_IN*WIDTH +: WIDTH];
      for (int k = 0; k < NUM_IN; k++) begin
         if (eff == SEL_W'(k)) pick = in_bus[k*WIDTH +: WIDTH];
      end
   end

   // Next state for the pipeline register: flush beats stall beats load.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      osel_d  = osel_q;
      if (flush) begin
         data_d  = '0;
         valid_d = 1'b0;
         osel_d  = '0;
      end else if (!stall) begin
         data_d  = pick;
         valid_d = in_valid;
         osel_d  = eff;
      end
   end

   // Sticky error and saturating counter; a new event outranks err_clr.
   always_comb begin
      bad_ev = in_valid && !sel_ok && !stall && !flush;
      err_d  = err_q;
      cnt_d  = cnt_q;
      if (bad_ev) begin
         err_d = 1'b1;
         if (err_clr)             cnt_d = 8'd1;
         else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else if (err_clr) begin
         err_d = 1'b0;
         cnt_d = 8'd0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         osel_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         osel_q  <= osel_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_sel   = osel_q;
   assign sel_err   = err_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed bench for pipe_sel_mux with 3 x 32-bit inputs.
// Expected values are hand-computed constants.
module tb_pipe_sel_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [95:0] in_bus;
   logic [1:0]  sel;
   logic        in_valid, stall, flush, err_clr;
   logic [31:0] out_data;
   logic        out_valid;
   logic [1:0]  out_sel;
   logic        sel_err;
   logic [7:0]  err_count;

   int total = 0;
   int bad   = 0;

   pipe_sel_mux #(
      .WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_IN(0)
   ) dut (
      .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel),
      .in_valid(in_valid), .stall(stall), .flush(flush),
      .err_clr(err_clr), .out_data(out_data),
      .out_valid(out_valid), .out_sel(out_sel),
      .sel_err(sel_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [31:0] d,
                          input logic v, input logic [1:0] s,
                          input logic e, input logic [7:0] c);
      chk({tag, ".data"}, out_data, d);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".sel"}, 32'(out_sel), 32'(s));
      chk({tag, ".err"}, 32'(sel_err), 32'(e));
      chk({tag, ".cnt"}, 32'(err_count), 32'(c));
   endtask

   initial begin
      rst = 1'b1;
      in_bus = {32'h33333333, 32'h22222222, 32'h11111111};
      sel = 2'd0; in_valid = 1'b0; stall = 1'b0;
      flush = 1'b0; err_clr = 1'b0;
      tick();
      chk_all("reset", 32'h0, 1'b0, 2'd0, 1'b0, 8'd0);
      rst = 1'b0;

      sel = 2'd1; in_valid = 1'b1;
      tick();
      chk_all("sel1", 32'h22222222, 1'b1, 2'd1, 1'b0, 8'd0);
      sel = 2'd2;
      tick();
      chk_all("sel2", 32'h33333333, 1'b1, 2'd2, 1'b0, 8'd0);

      sel = 2'd0;
      tick();
      chk("sel0.data", out_data, 32'h11111111);
      stall = 1'b1; sel = 2'd2;
      for (int i = 0; i < 3; i++) begin
         in_bus[95:64] = 32'h44444444 + 32'(i);
         tick();
         chk_all("stall", 32'h11111111, 1'b1, 2'd0, 1'b0, 8'd0);
      end
      stall = 1'b0;
      tick();
      chk_all("unstall", 32'h44444446, 1'b1, 2'd2, 1'b0, 8'd0);

      stall = 1'b1; flush = 1'b1;
      tick();
      chk_all("flush", 32'h0, 1'b0, 2'd0, 1'b0, 8'd0);
      stall = 1'b0; flush = 1'b0;

      sel = 2'd3; in_valid = 1'b1;
      tick();
      chk_all("illegal", 32'h11111111, 1'b1, 2'd0, 1'b1, 8'd1);
      in_valid = 1'b0;
      tick();
      chk_all("ill_nv", 32'h11111111, 1'b0, 2'd0, 1'b1, 8'd1);
      in_valid = 1'b1; stall = 1'b1;
      tick();
      chk_all("ill_stall", 32'h11111111, 1'b0, 2'd0, 1'b1, 8'd1);
      stall = 1'b0; flush = 1'b1;
      tick();
      chk_all("ill_flush", 32'h0, 1'b0, 2'd0, 1'b1, 8'd1);
      flush = 1'b0;

      for (int i = 0; i < 300; i++) tick();
      chk("sat.cnt", 32'(err_count), 32'd255);
      err_clr = 1'b1;
      tick();
      chk_all("clr_ev", 32'h11111111, 1'b1, 2'd0, 1'b1, 8'd1);
      in_valid = 1'b0;
      tick();
      chk_all("clr", 32'h11111111, 1'b0, 2'd0, 1'b0, 8'd0);
      err_clr = 1'b0;

      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk_all("five", 32'h11111111, 1'b1, 2'd0, 1'b1, 8'd5);
      sel = 2'd1;
      stall = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 32'h0, 1'b0, 2'd0, 1'b0, 8'd0);
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; sel = 2'd2;
      tick();
      chk_all("post_rst", 32'h44444446, 1'b1, 2'd2, 1'b0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
